// File: rtl/fpd_round_pack.sv
// Round-and-pack back end for a single-precision divider.
// Stage 1 normalises the raw quotient and rounds it to nearest even.
// Stage 2 range-checks the exponent, applies the special cases and packs
// the IEEE-754 word together with the {overflow, underflow, inexact} flags.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high at that port. in_ready is combinational:
// S1 empty, or S1 moving into S2 this cycle. out_valid and out_ready follow
// the same rule. While the consumer stalls with both stages full, every
// register, including the output word, holds its value.
module fpd_round_pack #(
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic signed [9:0]  in_exp,
  input  logic [26:0]        in_q,
  input  logic               in_rem_nz,
  input  logic [1:0]         in_special,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_ieee,
  output logic [2:0]         out_flags
);

  localparam logic [1:0] SP_ZERO = 2'b01;
  localparam logic [1:0] SP_INF  = 2'b10;
  localparam logic [1:0] SP_NAN  = 2'b11;

  // Stage 1 registers: rounded fraction (hidden bit implied), exponent, sticky state
  logic               s1_valid;
  logic               s1_sign;
  logic [1:0]         s1_special;
  logic signed [9:0]  s1_exp;
  logic [22:0]        s1_frac;
  logic               s1_inexact;

  // Stage 2 registers drive the outputs directly
  logic               s2_valid;
  logic [31:0]        s2_ieee;
  logic [2:0]         s2_flags;

  logic               s2_adv;

  // Normalise / round datapath
  logic [23:0]        mant_n;
  logic               guard;
  logic               sticky;
  logic signed [9:0]  exp_n;
  logic               round_up;
  logic [24:0]        mant_sum;
  logic [22:0]        frac_r;
  logic signed [9:0]  exp_r;
  logic               inexact_n;

  // Pack datapath
  logic [31:0]        pack_ieee;
  logic [2:0]         pack_flags;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;
  assign out_ieee  = s2_ieee;
  assign out_flags = s2_flags;

  // Normalise the quotient to a 24-bit mantissa and round to nearest even
  always_comb begin
    mant_n    = in_q[25:2];
    guard     = in_q[1];
    sticky    = in_q[0] | in_rem_nz;
    exp_n     = in_exp - 10'sd1;
    if (in_q[26]) begin
      mant_n = in_q[26:3];
      guard  = in_q[2];
      sticky = (|in_q[1:0]) | in_rem_nz;
      exp_n  = in_exp;
    end
    round_up  = guard & (sticky | mant_n[0]);
    inexact_n = guard | sticky;
    mant_sum  = {1'b0, mant_n} + {24'd0, round_up};
    // A carry out of the mantissa renormalises by one place: 1.000.. x 2^(e+1)
    if (mant_sum[24]) begin
      frac_r = mant_sum[23:1];
      exp_r  = exp_n + 10'sd1;
    end else begin
      frac_r = mant_sum[22:0];
      exp_r  = exp_n;
    end
  end

  // Range-check the rounded exponent and pack, special operands take priority
  always_comb begin
    pack_ieee  = {s1_sign, s1_exp[7:0], s1_frac};
    pack_flags = {2'b00, s1_inexact};
    case (s1_special)
      SP_ZERO: begin
        pack_ieee  = {s1_sign, 31'd0};
        pack_flags = 3'b000;
      end
      SP_INF: begin
        pack_ieee  = {s1_sign, 8'hFF, 23'd0};
        pack_flags = 3'b000;
      end
      SP_NAN: begin
        pack_ieee  = QNAN;
        pack_flags = 3'b000;
      end
      default: begin
        if (s1_exp >= 10'sd255) begin
          pack_ieee  = {s1_sign, 8'hFF, 23'd0};
          pack_flags = 3'b101;
        end else if (s1_exp <= 10'sd0) begin
          pack_ieee  = {s1_sign, 31'd0};
          pack_flags = 3'b011;
        end
      end
    endcase
  end

  // Stage 1 register: loads whenever the port is ready, captures data on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_special <= 2'b00;
      s1_exp     <= '0;
      s1_frac    <= '0;
      s1_inexact <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign    <= in_sign;
        s1_special <= in_special;
        s1_exp     <= exp_r;
        s1_frac    <= frac_r;
        s1_inexact <= inexact_n;
      end
    end
  end

  // Stage 2 register: advances when empty or drained by the consumer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_ieee  <= '0;
      s2_flags <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ieee  <= pack_ieee;
        s2_flags <= pack_flags;
      end
    end
  end

endmodule

// File: tb/tb_fpd_round_pack.sv
// Bench for fpd_round_pack: directed vector table, backpressure and reset
// sequences, then randomized traffic scored against an arithmetic model.
module tb_fpd_round_pack;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic signed [9:0] in_exp;
  logic [26:0]       in_q;
  logic              in_rem_nz;
  logic [1:0]        in_special;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_ieee;
  logic [2:0]        out_flags;

  fpd_round_pack #(.QNAN(32'h7FC00000)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_q       (in_q),
    .in_rem_nz  (in_rem_nz),
    .in_special (in_special),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ieee   (out_ieee),
    .out_flags  (out_flags)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              sign;
    logic signed [9:0] ex;
    logic [26:0]       q;
    logic              rem;
    logic [1:0]        sp;
    logic [31:0]       ieee;
    logic [2:0]        flags;
  } vec_t;

  vec_t        vecs[14];
  logic [34:0] exp_q[$];
  logic [34:0] cur_exp;
  logic        acc;
  logic        rand_ready;
  int          pass_cnt;
  int          total_cnt;
  int          out_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Reference: value-level rounding of q * 2^(exp-127) with remainder sticky
  function automatic logic [34:0] ref_model(input logic sign, input logic signed [9:0] ex,
                                            input logic [26:0] q, input logic rem_nz,
                                            input logic [1:0] sp);
    int     e;
    int     sh;
    longint mant;
    longint low;
    longint half;
    logic   up;
    logic   inx;
    if (sp == 2'b01) return {sign, 31'd0, 3'b000};
    if (sp == 2'b10) return {sign, 8'hFF, 23'd0, 3'b000};
    if (sp == 2'b11) return {32'h7FC00000, 3'b000};
    e  = ex;
    sh = (q >= 27'h4000000) ? 3 : 2;
    if (sh == 2) e = e - 1;
    mant = longint'(q) / (longint'(1) << sh);
    low  = longint'(q) % (longint'(1) << sh);
    half = (longint'(1) << sh) / 2;
    up   = (low > half) || ((low == half) && (rem_nz || (mant % 2 == 1)));
    inx  = (low != 0) || rem_nz;
    if (up) mant = mant + 1;
    if (mant == (longint'(1) << 24)) begin
      mant = mant / 2;
      e    = e + 1;
    end
    if (e >= 255) return {sign, 8'hFF, 23'd0, 3'b101};
    if (e <= 0)   return {sign, 31'd0, 3'b011};
    return {sign, 8'(e), 23'(mant), 2'b00, inx};
  endfunction

  // One clock: scoreboard at the falling edge, then move to just after the rising edge
  task automatic tick();
    logic [34:0] e;
    @(negedge clk);
    acc = 1'b0;
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        acc = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("unexpected_out%0d", out_idx), {29'd0, out_ieee, out_flags}, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("out%0d", out_idx), {29'd0, out_ieee, out_flags}, {29'd0, e});
        end
        out_idx++;
      end
    end
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Driver: present one input until accepted (bounded)
  task automatic send(input logic s, input logic signed [9:0] ex, input logic [26:0] q,
                      input logic r, input logic [1:0] sp, input logic [34:0] expv);
    int n;
    in_sign    = s;
    in_exp     = ex;
    in_q       = q;
    in_rem_nz  = r;
    in_special = sp;
    cur_exp    = expv;
    in_valid   = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  initial begin
    logic [31:0]       hold;
    logic [26:0]       q;
    logic signed [9:0] ex;
    logic [1:0]        sp;
    logic              s;
    logic              r;
    int                pick;

    pass_cnt = 0; total_cnt = 0; out_idx = 0;
    rand_ready = 1'b0; acc = 1'b0; cur_exp = '0;
    in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_q = '0;
    in_rem_nz = 1'b0; in_special = 2'b00; out_ready = 1'b1;

    vecs[0]  = '{1'b0, 10'sd127,  27'h4000000, 1'b0, 2'b00, 32'h3F800000, 3'b000};
    vecs[1]  = '{1'b0, 10'sd127,  27'h4000004, 1'b0, 2'b00, 32'h3F800000, 3'b001};
    vecs[2]  = '{1'b0, 10'sd127,  27'h400000C, 1'b0, 2'b00, 32'h3F800002, 3'b001};
    vecs[3]  = '{1'b0, 10'sd127,  27'h7FFFFFC, 1'b0, 2'b00, 32'h40000000, 3'b001};
    vecs[4]  = '{1'b0, 10'sd254,  27'h7FFFFFC, 1'b0, 2'b00, 32'h7F800000, 3'b101};
    vecs[5]  = '{1'b1, 10'sd1,    27'h2000000, 1'b0, 2'b00, 32'h80000000, 3'b011};
    vecs[6]  = '{1'b0, 10'sd127,  27'h4000000, 1'b0, 2'b11, 32'h7FC00000, 3'b000};
    vecs[7]  = '{1'b1, 10'sd300,  27'h5555555, 1'b1, 2'b01, 32'h80000000, 3'b000};
    vecs[8]  = '{1'b1, -10'sd100, 27'h2000000, 1'b0, 2'b10, 32'hFF800000, 3'b000};
    vecs[9]  = '{1'b0, 10'sd127,  27'h4000004, 1'b1, 2'b00, 32'h3F800001, 3'b001};
    vecs[10] = '{1'b0, 10'sd128,  27'h2000000, 1'b0, 2'b00, 32'h3F800000, 3'b000};
    vecs[11] = '{1'b0, -10'sd126, 27'h7FFFFFF, 1'b0, 2'b00, 32'h00000000, 3'b011};
    vecs[12] = '{1'b1, 10'sd381,  27'h2000000, 1'b0, 2'b00, 32'hFF800000, 3'b101};
    vecs[13] = '{1'b0, 10'sd255,  27'h2000000, 1'b0, 2'b00, 32'h7F000000, 3'b000};

    // Reset block
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ieee",  64'(out_ieee),  64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    rst = 1'b0;
    tick();

    // Single vector latency: out_valid exactly two edges after accept
    send(vecs[0].sign, vecs[0].ex, vecs[0].q, vecs[0].rem, vecs[0].sp,
         {vecs[0].ieee, vecs[0].flags});
    chk("latency_one_edge", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("latency_two_edges", 64'(out_valid), 64'd1);
    drain();

    // Directed table, back-to-back
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("model_vs_table%0d", i),
          64'(ref_model(vecs[i].sign, vecs[i].ex, vecs[i].q, vecs[i].rem, vecs[i].sp)),
          64'({vecs[i].ieee, vecs[i].flags}));
      send(vecs[i].sign, vecs[i].ex, vecs[i].q, vecs[i].rem, vecs[i].sp,
           {vecs[i].ieee, vecs[i].flags});
    end
    drain();

    // Backpressure: two accepts fill the pipe, then in_ready drops and output holds
    out_ready = 1'b0;
    send(1'b0, 10'sd130, 27'h4800000, 1'b0, 2'b00, ref_model(1'b0, 10'sd130, 27'h4800000, 1'b0, 2'b00));
    send(1'b1, 10'sd100, 27'h3000001, 1'b1, 2'b00, ref_model(1'b1, 10'sd100, 27'h3000001, 1'b1, 2'b00));
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    hold = out_ieee;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_stable%0d", i), 64'(out_ieee), 64'(hold));
    end
    out_ready = 1'b1;
    send(1'b0, 10'sd2,   27'h7FFFFFF, 1'b0, 2'b00, ref_model(1'b0, 10'sd2,   27'h7FFFFFF, 1'b0, 2'b00));
    send(1'b1, 10'sd200, 27'h5A5A5A5, 1'b0, 2'b00, ref_model(1'b1, 10'sd200, 27'h5A5A5A5, 1'b0, 2'b00));
    drain();

    // Reset with both stages full, then a fresh transaction
    out_ready = 1'b0;
    send(1'b0, 10'sd127, 27'h4000000, 1'b0, 2'b00, 35'd0);
    send(1'b0, 10'sd127, 27'h4000000, 1'b0, 2'b00, 35'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_ieee",  64'(out_ieee),  64'd0);
    chk("mid_rst_out_flags", 64'(out_flags), 64'd0);
    chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(1'b1, 10'sd127, 27'h400000C, 1'b0, 2'b00, {32'hBF800002, 3'b001});
    drain();

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      s    = 1'($urandom_range(0, 1));
      r    = 1'($urandom_range(0, 1));
      q    = 27'($urandom_range(32'h7FFFFFF, 32'h2000000));
      pick = $urandom_range(0, 7);
      if (pick == 0) q = q[26] ? 27'h7FFFFFF : 27'h3FFFFFF;
      else if (pick == 1) begin
        if (q[26]) q[2:0] = 3'b100;
        else q[1:0] = 2'b10;
      end
      pick = $urandom_range(0, 3);
      if (pick == 0)      ex = 10'($urandom_range(0, 6)) - 10'sd2;
      else if (pick == 1) ex = 10'($urandom_range(250, 258));
      else                ex = 10'($urandom_range(0, 507)) - 10'sd126;
      sp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send(s, ex, q, r, sp, ref_model(s, ex, q, r, sp));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fpd_round_pack.md
FPD_ROUND_PACK -- requirements
Module: fpd_round_pack

Interface
REQ-001 The block SHALL have one parameter: QNAN, default 32'h7FC00000, canonical NaN output pattern.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: divider result present this cycle.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block accepts the input this cycle.
REQ-006 The block SHALL have port in_sign, input, 1 bit: quotient sign (sign1 XOR sign2).
REQ-007 The block SHALL have port in_exp, input, 10 bits: two's-complement biased exponent (exp1-exp2+127), range -126..381.
REQ-008 The block SHALL have port in_q, input, 27 bits: raw quotient; bit26 weighs 2^0, bits25..0 weigh 2^-1..2^-26; value in [0.5,2).
REQ-009 The block SHALL have port in_rem_nz, input, 1 bit: divider remainder non-zero (sticky).
REQ-010 The block SHALL have port in_special, input, 2 bits: 00 normal, 01 zero, 10 infinity, 11 NaN.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 The block SHALL have port out_ieee, output, 32 bits: packed single-precision result.
REQ-014 The block SHALL have port out_flags, output, 3 bits: {overflow, underflow, inexact}.

Function
REQ-015 Transfers SHALL occur only on cycles where valid and ready are both high, at each port.
REQ-016 The block SHALL be a 2-stage pipeline: S1 normalise/round, S2 range-check/pack; input-accept to out_valid latency SHALL be 2 cycles with no stall.
REQ-017 S1 SHALL advance when S2 is empty or out_ready=1; in_ready SHALL equal (S1 empty OR S1 advancing), giving full throughput of one result per cycle.
REQ-018 While out_valid=1 and out_ready=0, out_ieee and out_flags SHALL hold stable and no register SHALL change.
REQ-019 Normalise: if q[26]=1, mant=q[26:3], guard=q[2], sticky=q[1]|q[0]|rem_nz, exp=in_exp; otherwise mant=q[25:2], guard=q[1], sticky=q[0]|rem_nz, exp=in_exp-1.
REQ-020 Round to nearest even: round_up = guard AND (sticky OR mant[0]); inexact = guard OR sticky.
REQ-021 Mantissa carry-out on rounding (mant=24'hFFFFFF) SHALL yield mant=24'h800000 and exp+1.
REQ-022 Exp >= 255 after rounding SHALL produce signed infinity, with overflow=1 and inexact=1.
REQ-023 Exp <= 0 after rounding SHALL produce signed zero (flush, no denormals), with underflow=1 and inexact=1.
REQ-024 Otherwise the result SHALL be {sign, exp[7:0], mant[22:0]}.
REQ-025 in_special 01 SHALL output {sign,31'b0}; 10 SHALL output {sign,8'hFF,23'b0}; 11 SHALL output QNAN; all three with flags=000, ignoring in_q and in_exp.
REQ-026 Exponent arithmetic SHALL be 10-bit signed; no wrap SHALL reach the output.

Reset
REQ-027 Asserting rst SHALL immediately clear both stage valids, so out_valid=0, out_ieee=0 and out_flags=0.
REQ-028 After reset in_ready SHALL be 1; reset mid-operation SHALL discard in-flight results with no partial output.

Verification
REQ-029 in_q=27'h4000000, exp=127, sign=0, normal -> out_ieee=32'h3F800000, flags=000, two cycles after accept.
REQ-030 Ties: in_q=27'h4000004, exp=127 -> 32'h3F800000, flags=001; in_q=27'h400000C -> 32'h3F800002, flags=001.
REQ-031 Carry and overflow: in_q=27'h7FFFFFC, exp=127 -> 32'h40000000, flags=001; same q with exp=254 -> 32'h7F800000, flags=101.
REQ-032 Underflow and specials: in_q=27'h2000000, exp=1, sign=1 -> 32'h80000000, flags=011; in_special=11 -> 32'h7FC00000, flags=000.
REQ-033 Backpressure: stream 4 inputs with out_ready low for 3 cycles -> in_ready drops after 2 accepts; all 4 results emerge in order, no loss or duplication; out_ieee stable while stalled.
REQ-034 Assert rst with both stages full -> out_valid=0 immediately; the next accepted input emerges correctly.
